// File: rtl/tt_equiv_checker_pkg.sv
// rtl/tt_equiv_checker_pkg.sv - shared state encoding and width helpers for the equivalence checker
package tt_equiv_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_PRESENT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // mis_count must hold every row of the sweep, i.e. 2**n_in
    function automatic int mis_w(input int n_in);
        return n_in + 1;
    endfunction

    function automatic int settle_w(input int settle);
        return $clog2(settle + 1) + 1;
    endfunction

endpackage

// File: rtl/tt_vec_counter.sv
// rtl/tt_vec_counter.sv - truth-table vector counter with clear, increment and last-vector flag
module tt_vec_counter #(
    parameter int N_IN = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            inc,
    output logic [N_IN-1:0] count,
    output logic            last
);

    logic [N_IN-1:0] count_q;
    logic [N_IN-1:0] count_d;

    assign last  = (count_q == {N_IN{1'b1}});
    assign count = count_q;

    // The last vector ends the sweep, so the counter never wraps
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && !last) begin
            count_d = count_q + {{(N_IN-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/tt_equiv_checker.sv
// rtl/tt_equiv_checker.sv - sweeps all input vectors into two DUTs and streams per-row comparisons
module tt_equiv_checker
    import tt_equiv_checker_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int N_OUT  = 1,
    parameter int SETTLE = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [N_IN-1:0]    stim,
    input  logic [N_OUT-1:0]   dut_a,
    input  logic [N_OUT-1:0]   dut_b,
    output logic               row_valid,
    input  logic               row_ready,
    output logic [N_IN-1:0]    row_vec,
    output logic [N_OUT-1:0]   row_a,
    output logic [N_OUT-1:0]   row_b,
    output logic               row_mis,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [N_IN:0]      mis_count,
    output logic [N_IN-1:0]    first_fail
);

    localparam int MW = mis_w(N_IN);
    localparam int SW = settle_w(SETTLE);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE);

    state_t state_q, state_d;

    logic [SW-1:0]    settle_q, settle_d;
    logic [N_IN-1:0]  row_vec_q, row_vec_d;
    logic [N_OUT-1:0] row_a_q, row_a_d;
    logic [N_OUT-1:0] row_b_q, row_b_d;
    logic             row_mis_q, row_mis_d;
    logic [MW-1:0]    mis_count_q, mis_count_d;
    logic [N_IN-1:0]  first_fail_q, first_fail_d;
    logic             pass_q, pass_d;
    logic             done_q, done_d;

    logic            start_ok;
    logic            sample;
    logic            accept;
    logic            mis_now;
    logic            vec_last;
    logic            vec_inc;
    logic [N_IN-1:0] vec;

    tt_vec_counter #(.N_IN(N_IN)) u_vec_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_ok),
        .inc   (vec_inc),
        .count (vec),
        .last  (vec_last)
    );

    // A start coinciding with the done pulse is dropped; DONE accepts it one cycle later
    assign start_ok = start && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && !done_q));
    assign sample   = (state_q == ST_SETTLE) && (settle_q == SETTLE_LAST);
    assign accept   = (state_q == ST_PRESENT) && row_ready;
    assign vec_inc  = accept && !vec_last;
    assign mis_now  = (dut_a != dut_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:    if (start_ok) state_d = ST_SETTLE;
            ST_SETTLE:  if (sample)   state_d = ST_PRESENT;
            ST_PRESENT: if (accept)   state_d = vec_last ? ST_DONE : ST_SETTLE;
            ST_DONE:    if (start_ok) state_d = ST_SETTLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q == ST_SETTLE) || (state_q == ST_PRESENT);
        row_valid = (state_q == ST_PRESENT);
    end

    // Settle count runs 0..SETTLE so the row appears SETTLE+1 cycles after the vector
    always_comb begin
        settle_d     = '0;
        row_vec_d    = row_vec_q;
        row_a_d      = row_a_q;
        row_b_d      = row_b_q;
        row_mis_d    = row_mis_q;
        mis_count_d  = mis_count_q;
        first_fail_d = first_fail_q;
        pass_d       = pass_q;
        done_d       = accept && vec_last;

        if ((state_q == ST_SETTLE) && !sample) begin
            settle_d = settle_q + {{(SW-1){1'b0}}, 1'b1};
        end

        if (sample) begin
            row_vec_d = vec;
            row_a_d   = dut_a;
            row_b_d   = dut_b;
            row_mis_d = mis_now;
            if (mis_now) begin
                mis_count_d = mis_count_q + {{(MW-1){1'b0}}, 1'b1};
                if (mis_count_q == '0) begin
                    first_fail_d = vec;
                end
            end
        end

        if (accept && vec_last) begin
            pass_d = (mis_count_q == '0);
        end

        if (start_ok) begin
            mis_count_d  = '0;
            first_fail_d = '0;
            pass_d       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            settle_q     <= '0;
            row_vec_q    <= '0;
            row_a_q      <= '0;
            row_b_q      <= '0;
            row_mis_q    <= 1'b0;
            mis_count_q  <= '0;
            first_fail_q <= '0;
            pass_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            settle_q     <= settle_d;
            row_vec_q    <= row_vec_d;
            row_a_q      <= row_a_d;
            row_b_q      <= row_b_d;
            row_mis_q    <= row_mis_d;
            mis_count_q  <= mis_count_d;
            first_fail_q <= first_fail_d;
            pass_q       <= pass_d;
            done_q       <= done_d;
        end
    end

    assign stim       = vec;
    assign row_vec    = row_vec_q;
    assign row_a      = row_a_q;
    assign row_b      = row_b_q;
    assign row_mis    = row_mis_q;
    assign mis_count  = mis_count_q;
    assign first_fail = first_fail_q;
    assign pass       = pass_q;
    assign done       = done_q;

endmodule

// File: tb/tb_tt_equiv_checker.sv
// tb/tb_tt_equiv_checker.sv - directed table-driven bench for tt_equiv_checker
module tb_tt_equiv_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    // DUT1: N_IN=2, N_OUT=1, SETTLE=1; A is either a&b or a wrong xor-based AND
    logic       start1, ready1, wrong_a;
    logic [1:0] stim1, row_vec1, first_fail1;
    logic       a1, b1, row_valid1, row_a1, row_b1, row_mis1, busy1, done1, pass1;
    logic [2:0] mis_count1;

    always_comb begin
        b1 = stim1[1] & stim1[0];
        a1 = wrong_a ? ((stim1[1] ^ stim1[0]) | (stim1[1] & stim1[0])) : (stim1[1] & stim1[0]);
    end

    tt_equiv_checker #(.N_IN(2), .N_OUT(1), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .stim(stim1),
        .dut_a(a1), .dut_b(b1), .row_valid(row_valid1), .row_ready(ready1),
        .row_vec(row_vec1), .row_a(row_a1), .row_b(row_b1), .row_mis(row_mis1),
        .busy(busy1), .done(done1), .pass(pass1), .mis_count(mis_count1),
        .first_fail(first_fail1)
    );

    // DUT2: N_IN=3, N_OUT=2, SETTLE=3; parity+majority, structural vs behavioural
    logic       start2, ready2;
    logic [2:0] stim2, row_vec2, first_fail2;
    logic [1:0] a2, b2, row_a2, row_b2;
    logic       row_valid2, row_mis2, busy2, done2, pass2;
    logic [3:0] mis_count2;

    always_comb begin
        a2 = {stim2[0] ^ stim2[1] ^ stim2[2],
              (stim2[0] & stim2[1]) | (stim2[0] & stim2[2]) | (stim2[1] & stim2[2])};
        b2 = {^stim2, (2'(stim2[0]) + 2'(stim2[1]) + 2'(stim2[2])) >= 2'd2};
    end

    tt_equiv_checker #(.N_IN(3), .N_OUT(2), .SETTLE(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .stim(stim2),
        .dut_a(a2), .dut_b(b2), .row_valid(row_valid2), .row_ready(ready2),
        .row_vec(row_vec2), .row_a(row_a2), .row_b(row_b2), .row_mis(row_mis2),
        .busy(busy2), .done(done2), .pass(pass2), .mis_count(mis_count2),
        .first_fail(first_fail2)
    );

    typedef struct {
        logic       wrong;
        logic [1:0] vec;
        logic       exp_a;
        logic       exp_b;
        logic       exp_mis;
    } row_t;

    typedef struct {
        logic [2:0] exp_mis_count;
        logic [1:0] exp_first_fail;
        logic       exp_pass;
    } sum_t;

    row_t tbl[8];
    sum_t sum_tbl[2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: timeout waiting for DUT", name);
    endtask

    // One DUT1 sweep; optional stall on a row, start pulse mid-sweep, start in the done cycle
    task automatic sweep(input logic wrong, input int stall_row, input bit start_mid,
                         input bit start_done);
        int   base;
        bit   found;
        wrong_a = wrong;
        base    = wrong ? 4 : 0;
        ready1  = 1'b0;
        start1  = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("start_busy", 32'(busy1), 32'd1);
        chk("start_stim", 32'(stim1), 32'd0);
        chk("start_mis_cleared", 32'(mis_count1), 32'd0);
        chk("start_ff_cleared", 32'(first_fail1), 32'd0);
        chk("start_pass_cleared", 32'(pass1), 32'd0);
        for (int i = 0; i < 4; i++) begin
            found = 1'b0;
            for (int c = 0; c < 20; c++) begin
                if (row_valid1) begin
                    found = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!found) begin
                timeout("row_valid1");
                return;
            end
            chk("row_vec", 32'(row_vec1), 32'(tbl[base+i].vec));
            chk("row_a", 32'(row_a1), 32'(tbl[base+i].exp_a));
            chk("row_b", 32'(row_b1), 32'(tbl[base+i].exp_b));
            chk("row_mis", 32'(row_mis1), 32'(tbl[base+i].exp_mis));
            if (i == stall_row) begin
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    chk("stall_valid", 32'(row_valid1), 32'd1);
                    chk("stall_stim", 32'(stim1), 32'(i));
                    chk("stall_vec", 32'(row_vec1), 32'(i));
                    chk("stall_a", 32'(row_a1), 32'(tbl[base+i].exp_a));
                end
            end
            if (start_mid && i == 1) start1 = 1'b1;
            ready1 = 1'b1;
            @(negedge clk);
            ready1 = 1'b0;
            start1 = 1'b0;
            if (i < 3) chk("next_stim", 32'(stim1), 32'(i + 1));
        end
        chk("done_pulse", 32'(done1), 32'd1);
        chk("done_busy", 32'(busy1), 32'd0);
        chk("done_stim", 32'(stim1), 32'd3);
        chk("done_pass", 32'(pass1), 32'(sum_tbl[wrong].exp_pass));
        chk("done_mis_count", 32'(mis_count1), 32'(sum_tbl[wrong].exp_mis_count));
        chk("done_first_fail", 32'(first_fail1), 32'(sum_tbl[wrong].exp_first_fail));
        if (start_done) start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        chk("done_one_cycle", 32'(done1), 32'd0);
        chk("after_done_busy", 32'(busy1), 32'd0);
        chk("after_done_stim", 32'(stim1), 32'd3);
        chk("after_done_pass", 32'(pass1), 32'(sum_tbl[wrong].exp_pass));
    endtask

    initial begin
        int         t_change;
        int         k;
        bit         done_seen;
        logic [2:0] last_stim;
        logic       last_busy;
        logic [2:0] kv;
        bit         found;

        tbl[0] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 2'd1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 2'd2, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 2'd3, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 2'd0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 2'd2, 1'b1, 1'b0, 1'b1};
        tbl[7] = '{1'b1, 2'd3, 1'b1, 1'b1, 1'b0};
        sum_tbl[0] = '{3'd0, 2'd0, 1'b1};
        sum_tbl[1] = '{3'd2, 2'd1, 1'b0};

        rst_n = 1'b0; start1 = 1'b0; ready1 = 1'b0; wrong_a = 1'b0;
        start2 = 1'b0; ready2 = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs1", 32'({stim1, row_valid1, row_vec1, row_a1, row_b1, row_mis1,
                                   busy1, done1, pass1, mis_count1, first_fail1}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs2", 32'({stim2, row_valid2, busy2, done2, pass2, mis_count2}), 32'd0);

        // SETTLE=3 latency: every row_valid 4 cycles after its stim change
        last_stim = stim2; last_busy = busy2; k = 0; t_change = 0; done_seen = 1'b0;
        start2 = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            start2 = 1'b0;
            if ((busy2 && !last_busy) || (stim2 != last_stim)) t_change = c;
            if (row_valid2) begin
                kv = 3'(k);
                chk("d2_row_vec", 32'(row_vec2), 32'(kv));
                chk("d2_latency", 32'(c - t_change), 32'd4);
                chk("d2_row_a", 32'(row_a2), 32'({^kv, (kv[0] & kv[1]) | (kv[0] & kv[2]) | (kv[1] & kv[2])}));
                k++;
            end
            if (done2) begin
                done_seen = 1'b1;
                break;
            end
            last_stim = stim2; last_busy = busy2;
        end
        if (!done_seen) timeout("d2_done");
        chk("d2_rows", 32'(k), 32'd8);
        chk("d2_pass", 32'(pass2), 32'd1);
        chk("d2_mis_count", 32'(mis_count2), 32'd0);
        chk("d2_stim_last", 32'(stim2), 32'd7);

        sweep(1'b0, -1, 1'b0, 1'b0);
        sweep(1'b1, -1, 1'b0, 1'b0);
        sweep(1'b1,  2, 1'b0, 1'b0);
        sweep(1'b1, -1, 1'b1, 1'b1);
        sweep(1'b0, -1, 1'b0, 1'b0);

        // Async reset in the SETTLE phase of vector 01
        wrong_a = 1'b1; ready1 = 1'b1; start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (stim1 == 2'd1 && !row_valid1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!found) timeout("reach_settle_01");
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({stim1, row_valid1, row_vec1, row_a1, row_b1, row_mis1,
                                        busy1, done1, pass1, mis_count1, first_fail1}), 32'd0);
        ready1 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", 32'(busy1), 32'd0);
        sweep(1'b0, -1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
